// File: rtl/whac_pkg.sv
// Shared types and helpers for the whac-a-mole hit detector.
package whac_pkg;

  typedef enum logic {IDLE, UP} mole_state_e;

  // Widest hole vector the popcount helper accepts; callers zero-extend into it.
  localparam int unsigned MaxHoles = 64;

  function automatic int unsigned popcount(input logic [MaxHoles-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxHoles; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/button_edge_detector.sv
// Per-bit 2-flop synchronizer plus a delay flop; press_o is a one-cycle rising-edge pulse.
module button_edge_detector #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] buttons_i,
  output logic [WIDTH-1:0] press_o
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] s3_q, s3_d;

  always_comb begin
    s1_d = buttons_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign press_o = s2_q & ~s3_q;

endmodule

// File: rtl/mole_hit_detector.sv
// Classifies player presses as hits/misses, keeps a saturating score and per-round stats.
// Define MISS_PENALTY_EN to make each miss subtract one point (floored at zero).
module mole_hit_detector
  import whac_pkg::*;
#(
  parameter int unsigned NUMBER_OF_HOLES = 18,
  parameter int unsigned SCORE_WIDTH     = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUMBER_OF_HOLES-1:0]           mole_positions,
  input  logic [NUMBER_OF_HOLES-1:0]           buttons,
  input  logic                                 enable,
  input  logic                                 clear_score,
  output logic                                 hit_pulse,
  output logic                                 miss_pulse,
  output logic [SCORE_WIDTH-1:0]               score,
  output logic [NUMBER_OF_HOLES-1:0]           whacked,
  output logic                                 round_done,
  output logic [$clog2(NUMBER_OF_HOLES+1)-1:0] escaped
);

  localparam int unsigned EscW = $clog2(NUMBER_OF_HOLES + 1);
  localparam int unsigned SumW = SCORE_WIDTH + 1;
  localparam logic [SumW-1:0] ScoreMax = {1'b0, {SCORE_WIDTH{1'b1}}};

  function automatic logic [MaxHoles-1:0] widen(input logic [NUMBER_OF_HOLES-1:0] v);
    logic [MaxHoles-1:0] w;
    w = '0;
    w[NUMBER_OF_HOLES-1:0] = v;
    return w;
  endfunction

  logic [NUMBER_OF_HOLES-1:0] press;

  button_edge_detector #(
    .WIDTH(NUMBER_OF_HOLES)
  ) u_button_edge_detector (
    .clk_i    (clk),
    .rst_i    (reset),
    .buttons_i(buttons),
    .press_o  (press)
  );

  mole_state_e                state_q, state_d;
  logic [NUMBER_OF_HOLES-1:0] mask_q, mask_d;
  logic [NUMBER_OF_HOLES-1:0] whacked_q, whacked_d;
  logic [SCORE_WIDTH-1:0]     score_q, score_d;
  logic                       hit_pulse_q, hit_pulse_d;
  logic                       miss_pulse_q, miss_pulse_d;
  logic                       round_done_q, round_done_d;
  logic [EscW-1:0]            escaped_q, escaped_d;

  logic [NUMBER_OF_HOLES-1:0] hits, misses;
  logic                       round_end;
  logic [SumW-1:0]            score_sum;
  logic [SCORE_WIDTH-1:0]     score_hit, score_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mole_positions != '0) state_d = UP;
      UP:      if (mole_positions == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign round_end = (state_q == UP) && (mole_positions == '0);

  always_comb begin
    // A press on an already-whacked hole is ignored entirely.
    hits   = press & mole_positions & ~whacked_q;
    misses = press & ~mole_positions & ~whacked_q;
    if (!enable) begin
      hits   = '0;
      misses = '0;
    end

    score_sum = {1'b0, score_q} + SumW'(popcount(widen(hits)));
    score_hit = (score_sum > ScoreMax) ? {SCORE_WIDTH{1'b1}} : score_sum[SCORE_WIDTH-1:0];

`ifdef MISS_PENALTY_EN
    if (SumW'(popcount(widen(misses))) >= {1'b0, score_hit}) begin
      score_next = '0;
    end else begin
      score_next = score_hit - SCORE_WIDTH'(popcount(widen(misses)));
    end
`else
    score_next = score_hit;
`endif

    score_d      = clear_score ? '0 : score_next;
    hit_pulse_d  = |hits;
    miss_pulse_d = |misses;
    round_done_d = round_end;
    whacked_d    = whacked_q | hits;
    mask_d       = mask_q | mole_positions;
    escaped_d    = escaped_q;
    if (round_end) begin
      escaped_d = EscW'(popcount(widen(mask_q & ~whacked_d)));
      whacked_d = '0;
      mask_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q       <= '0;
      whacked_q    <= '0;
      score_q      <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      round_done_q <= 1'b0;
      escaped_q    <= '0;
    end else begin
      mask_q       <= mask_d;
      whacked_q    <= whacked_d;
      score_q      <= score_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      round_done_q <= round_done_d;
      escaped_q    <= escaped_d;
    end
  end

  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign score      = score_q;
  assign whacked    = whacked_q;
  assign round_done = round_done_q;
  assign escaped    = escaped_q;

endmodule

// File: tb/tb_mole_hit_detector.sv
// Directed bench for mole_hit_detector with a scoreboard of expected press outcomes.
module tb_mole_hit_detector;

  localparam int unsigned N  = 18;
  localparam int unsigned SW = 10;
  localparam int ScoreMax    = 1023;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  mole_positions;
  logic [N-1:0]  buttons;
  logic          enable;
  logic          clear_score;
  logic          hit_pulse;
  logic          miss_pulse;
  logic [SW-1:0] score;
  logic [N-1:0]  whacked;
  logic          round_done;
  logic [4:0]    escaped;

  always #5 clk = ~clk;

  mole_hit_detector #(
    .NUMBER_OF_HOLES(N),
    .SCORE_WIDTH    (SW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mole_positions(mole_positions),
    .buttons       (buttons),
    .enable        (enable),
    .clear_score   (clear_score),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .score         (score),
    .whacked       (whacked),
    .round_done    (round_done),
    .escaped       (escaped)
  );

  typedef struct {
    string         tag;
    logic          hit;
    logic          miss;
    logic          done;
    logic [SW-1:0] score;
    logic [N-1:0]  whacked;
  } exp_t;

  exp_t         sb[$];
  int unsigned  passed = 0;
  int unsigned  total  = 0;
  int           m_score;
  logic [N-1:0] m_whacked;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one button press and checks the outcome three edges later.
  // With drop set, the moles fall in the very cycle the press is evaluated.
  task automatic do_press(input string tag, input logic [N-1:0] b, input logic clr,
                          input logic drop);
    logic [N-1:0] moles, h, m;
    exp_t e;
    moles = drop ? '0 : mole_positions;
    h = b & moles & ~m_whacked;
    m = b & ~moles & ~m_whacked;
    if (!enable) begin
      h = '0;
      m = '0;
    end
    m_whacked = m_whacked | h;
    m_score = m_score + $countones(h);
    if (m_score > ScoreMax) m_score = ScoreMax;
`ifdef MISS_PENALTY_EN
    m_score = m_score - $countones(m);
    if (m_score < 0) m_score = 0;
`endif
    if (clr) m_score = 0;
    if (drop) m_whacked = '0;
    e.tag = tag; e.hit = |h; e.miss = |m; e.done = drop;
    e.score = SW'(m_score); e.whacked = m_whacked;
    sb.push_back(e);

    buttons = b;
    tick();
    tick();
    clear_score = clr;
    if (drop) mole_positions = '0;
    tick();
    clear_score = 1'b0;
    buttons = '0;
    e = sb.pop_front();
    check({e.tag, "/hit"}, 32'(hit_pulse), 32'(e.hit));
    check({e.tag, "/miss"}, 32'(miss_pulse), 32'(e.miss));
    check({e.tag, "/score"}, 32'(score), 32'(e.score));
    check({e.tag, "/whacked"}, 32'(whacked), 32'(e.whacked));
    check({e.tag, "/round_done"}, 32'(round_done), 32'(e.done));
    tick();
    check({tag, "/hit_one_cycle"}, 32'(hit_pulse), 32'd0);
    check({tag, "/miss_one_cycle"}, 32'(miss_pulse), 32'd0);
    tick();
    tick();
  endtask

  task automatic end_round(input string tag, input int exp_esc);
    mole_positions = '0;
    tick();
    m_whacked = '0;
    check({tag, "/round_done"}, 32'(round_done), 32'd1);
    check({tag, "/escaped"}, 32'(escaped), 32'(exp_esc));
    check({tag, "/whacked_clear"}, 32'(whacked), 32'd0);
    tick();
    check({tag, "/round_done_one_cycle"}, 32'(round_done), 32'd0);
    check({tag, "/escaped_held"}, 32'(escaped), 32'(exp_esc));
  endtask

  task automatic start_round(input logic [N-1:0] moles);
    mole_positions = moles;
    tick();
  endtask

  task automatic do_clear(input string tag);
    clear_score = 1'b1;
    tick();
    clear_score = 1'b0;
    m_score = 0;
    check({tag, "/score"}, 32'(score), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/score"}, 32'(score), 32'd0);
    check({tag, "/whacked"}, 32'(whacked), 32'd0);
    check({tag, "/escaped"}, 32'(escaped), 32'd0);
    check({tag, "/hit"}, 32'(hit_pulse), 32'd0);
    check({tag, "/miss"}, 32'(miss_pulse), 32'd0);
    check({tag, "/round_done"}, 32'(round_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1;
    mole_positions = '0;
    buttons = '0;
    enable = 1'b0;
    clear_score = 1'b0;
    m_score = 0;
    m_whacked = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    enable = 1'b1;
    tick();

    // Single hit, then a re-press of the whacked hole does nothing.
    start_round(18'h00004);
    do_press("single_hit", 18'h00004, 1'b0, 1'b0);
    do_press("repress_whacked", 18'h00004, 1'b0, 1'b0);
    end_round("single_hit_end", 0);

    // Three moles, one hit: two escape.
    do_clear("clear0");
    start_round(18'h00221);
    do_press("one_of_three", 18'h00020, 1'b0, 1'b0);
    end_round("one_of_three_end", 2);

    // Misses: at score 0, and at score 3.
    do_clear("clear1");
    do_press("miss_at_zero", 18'h00080, 1'b0, 1'b0);
    start_round(18'h00007);
    do_press("three_hits", 18'h00007, 1'b0, 1'b0);
    do_press("miss_at_three", 18'h00080, 1'b0, 1'b0);
    end_round("three_hits_end", 0);

    // Two simultaneous hits, then re-press bit 1.
    start_round(18'h0000A);
    do_press("double_hit", 18'h0000A, 1'b0, 1'b0);
    do_press("double_repress", 18'h00002, 1'b0, 1'b0);
    end_round("double_end", 0);

    // Disabled: presses ignored, round tracking continues.
    start_round(18'h00010);
    enable = 1'b0;
    do_press("disabled_hit", 18'h00010, 1'b0, 1'b0);
    do_press("disabled_miss", 18'h00100, 1'b0, 1'b0);
    enable = 1'b1;
    end_round("disabled_end", 1);

    // clear_score wins over a same-cycle hit.
    start_round(18'h00001);
    do_press("clear_vs_hit", 18'h00001, 1'b1, 1'b0);
    end_round("clear_vs_hit_end", 0);

    // Press evaluated in the cycle the moles drop: a miss, mole escapes.
    start_round(18'h00040);
    do_press("drop_press", 18'h00040, 1'b0, 1'b1);
    check("drop_press/escaped", 32'(escaped), 32'd1);
    tick();
    check("drop_press/round_done_one_cycle", 32'(round_done), 32'd0);

    // Saturation: climb to 1020, then 5 more hits.
    do_clear("clear2");
    while (m_score + 18 <= 1020) begin
      start_round('1);
      do_press("climb", '1, 1'b0, 1'b0);
      end_round("climb_end", 0);
    end
    k = 1020 - m_score;
    start_round(N'((1 << k) - 1));
    do_press("climb_last", N'((1 << k) - 1), 1'b0, 1'b0);
    end_round("climb_last_end", 0);
    check("preload/score", 32'(score), 32'd1020);
    start_round(18'h0001F);
    do_press("saturate", 18'h0001F, 1'b0, 1'b0);
    end_round("saturate_end", 0);
    check("saturate/score", 32'(score), 32'd1023);

    // Reset mid-round discards it without round_done.
    start_round(18'h00003);
    do_press("pre_reset_hit", 18'h00001, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    m_score = 0;
    m_whacked = '0;
    check_all_zero("mid_up_reset");
    reset = 1'b0;
    mole_positions = '0;
    tick();
    check("post_reset/round_done_a", 32'(round_done), 32'd0);
    tick();
    check("post_reset/round_done_b", 32'(round_done), 32'd0);
    check("post_reset/escaped", 32'(escaped), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mole_hit_detector.md
MOLE_HIT_DETECTOR -- requirements
Module: mole_hit_detector

Interface
REQ-001 SHALL have parameter NUMBER_OF_HOLES, default 18: width of the hole vectors.
REQ-002 SHALL have parameter SCORE_WIDTH, default 10: width of the score counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mole_positions, input, NUMBER_OF_HOLES bits: moles currently up, in the clk domain.
REQ-006 SHALL have port buttons, input, NUMBER_OF_HOLES bits: raw, asynchronous, active-high player switches.
REQ-007 SHALL have port enable, input, 1 bit: game running; when low, presses are ignored.
REQ-008 SHALL have port clear_score, input, 1 bit: synchronous score clear.
REQ-009 SHALL have port hit_pulse, output, 1 bit: one-cycle pulse on at least one hit.
REQ-010 SHALL have port miss_pulse, output, 1 bit: one-cycle pulse on at least one miss.
REQ-011 SHALL have port score, output, SCORE_WIDTH bits: running score.
REQ-012 SHALL have port whacked, output, NUMBER_OF_HOLES bits: moles hit in the current round.
REQ-013 SHALL have port round_done, output, 1 bit: one-cycle pulse at round end.
REQ-014 SHALL have port escaped, output, $clog2(NUMBER_OF_HOLES+1) bits: moles not hit in the last round; held until the next round_done.

Function
REQ-015 SHALL pass each buttons bit through a 2-flop synchronizer and a third flop, with press[i] = s2[i] & ~s3[i].
REQ-016 SHALL assert hit_pulse, miss_pulse, score and whacked updates 3 clk edges after the first edge that samples buttons[i] high.
REQ-017 SHALL classify a press on hole i as a hit when mole_positions[i]=1 and whacked[i]=0, both sampled in the press cycle.
REQ-018 SHALL classify a press as a miss when mole_positions[i]=0, and SHALL ignore it when whacked[i]=1 (neither hit nor miss).
REQ-019 SHALL evaluate multiple simultaneous presses independently, with score += popcount(hits) in a single cycle.
REQ-020 SHALL saturate score at 2**SCORE_WIDTH-1 with no wrap-around.
REQ-021 SHALL use FSM states IDLE and UP: IDLE->UP when mole_positions != 0, and UP->IDLE when mole_positions == 0.
REQ-022 SHALL latch the round mask |= mole_positions in every cycle of UP, because moles may rise across cycles.
REQ-023 SHALL, on the UP->IDLE transition, pulse round_done for 1 cycle, set escaped = popcount(mask & ~whacked), and clear whacked and mask.
REQ-024 SHALL evaluate a press landing in the cycle the moles drop against the sampled mole_positions, making it a miss, and SHALL update whacked before the clear.
REQ-025 SHALL, with enable=0, suppress hits and misses and hold score, while round tracking continues.
REQ-026 SHALL give clear_score priority over any same-cycle score change, so that score=0 next cycle while hit_pulse still fires.

Reset
REQ-027 SHALL, on reset, set score=0, whacked=0, escaped=0, hit_pulse=0, miss_pulse=0, round_done=0, the FSM to IDLE, and all synchronizer flops to 0.
REQ-028 SHALL discard an in-flight round on reset mid-UP without producing round_done.

Configuration
REQ-029 SHALL, with MISS_PENALTY_EN defined, decrement score by popcount(misses) saturating at 0, with hits applied before misses in the same cycle.
REQ-030 SHALL, without MISS_PENALTY_EN, leave misses affecting only miss_pulse.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, UP) and the popcount function in package whac_pkg.
REQ-032 SHALL implement the synchronizer and edge detect in one sub-module, button_edge_detector, parameterised by width.

Verification
REQ-033 SHALL verify: mole_positions=0x00004 for 40 cycles, buttons[2] high at cycle 10 -> hit_pulse at cycle 13, score=1, whacked=0x4, later round_done with escaped=0.
REQ-034 SHALL verify: moles at bits 0, 5 and 9, press only bit 5 -> score=1, and at round end escaped=2.
REQ-035 SHALL verify: press bit 7 with no mole up -> miss_pulse, score unchanged; with MISS_PENALTY_EN and score=3 -> score=2, and with score=0 -> score stays 0.
REQ-036 SHALL verify: press bits 1 and 3 in the same cycle with both moles up -> score +2 in one cycle; then re-press bit 1 -> no pulse.
REQ-037 SHALL verify: score preloaded near 1023 with SCORE_WIDTH=10, 5 hits -> score=1023.
REQ-038 SHALL verify: reset asserted mid-UP -> all outputs 0 next cycle and no round_done pulse.
